alu_arbiter: RTL and testbench

- Shares one combinational ALU instance between two requesters (e.g. the execute stage and an address-generation or branch-compare path).
- Per-requester valid/ready request handshake, round-robin arbitration, and a registered one-cycle response back to the granted requester.
- Drives the ALU's op/A/B inputs and samples its result, so the ALU itself stays purely combinational.

---
 rtl/alu_arbiter.sv | 82 ++++++++
 tb/tb_alu_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters; result registered, 1-cycle latency.
// No response backpressure: ready depends only on the request valids and the last grant.
module alu_arbiter #(
   parameter int XLEN = 64,
   parameter int OPW  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [OPW-1:0]  req0_op,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [OPW-1:0]  req1_op,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic            rsp0_valid,
   output logic            rsp1_valid,
   output logic [XLEN-1:0] rsp_data,
   output logic [OPW-1:0]  alu_op,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_out
);

   typedef struct packed {
      logic [OPW-1:0]  op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } alu_req_t;

   logic     last_grant;
   logic     grant0;
   logic     grant1;
   alu_req_t alu_req;

   // last_grant == 1 means requester 0 wins the next tie
   always_comb begin
      grant0 = req0_valid & (~req1_valid | last_grant);
      grant1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Zero operands when idle so the ALU output is deterministic
   always_comb begin
      alu_req = '0;
      if (grant0) begin
         alu_req.op = req0_op;
         alu_req.a  = req0_a;
         alu_req.b  = req0_b;
      end else if (grant1) begin
         alu_req.op = req1_op;
         alu_req.a  = req1_a;
         alu_req.b  = req1_b;
      end
   end

   assign alu_op = alu_req.op;
   assign alu_a  = alu_req.a;
   assign alu_b  = alu_req.b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp_data   <= '0;
         last_grant <= 1'b1;
      end else begin
         rsp0_valid <= grant0;
         rsp1_valid <= grant1;
         if (grant0 | grant1) begin
            rsp_data   <= alu_out;
            last_grant <= grant1;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, reset corner sequences, then randomized traffic vs a reference model.
module tb_alu_arbiter;
   localparam int XLEN = 64;
   localparam int OPW  = 4;
   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2,
                          OP_AND = 4'd3, OP_OR = 4'd4, OP_SLL = 4'd5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req0_valid, req1_valid;
   logic            req0_ready, req1_ready;
   logic [OPW-1:0]  req0_op, req1_op;
   logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
   logic            rsp0_valid, rsp1_valid;
   logic [XLEN-1:0] rsp_data;
   logic [OPW-1:0]  alu_op;
   logic [XLEN-1:0] alu_a, alu_b, alu_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.XLEN(XLEN), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
   );

   // Environment ALU; undefined opcodes pass A through
   function automatic logic [XLEN-1:0] alu_f(input logic [OPW-1:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_XOR:  return a ^ b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_SLL:  return a << b[5:0];
         default: return a;
      endcase
   endfunction

   assign alu_out = alu_f(alu_op, alu_a, alu_b);

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v0, input logic [OPW-1:0] op0, input logic [XLEN-1:0] a0,
                        input logic [XLEN-1:0] b0, input logic v1, input logic [OPW-1:0] op1,
                        input logic [XLEN-1:0] a1, input logic [XLEN-1:0] b1);
      req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
   endtask

   task automatic check_mux(input logic g0, input logic g1);
      logic [OPW-1:0]  eop;
      logic [XLEN-1:0] ea, eb;
      eop = '0; ea = '0; eb = '0;
      if (g0) begin eop = req0_op; ea = req0_a; eb = req0_b; end
      else if (g1) begin eop = req1_op; ea = req1_a; eb = req1_b; end
      check("alu_op", XLEN'(alu_op), XLEN'(eop));
      check("alu_a", alu_a, ea);
      check("alu_b", alu_b, eb);
   endtask

   typedef struct {
      logic v0; logic [OPW-1:0] op0; logic [XLEN-1:0] a0, b0;
      logic v1; logic [OPW-1:0] op1; logic [XLEN-1:0] a1, b1;
      logic g0, g1, r0, r1; logic [XLEN-1:0] d;
   } vec_t;

   vec_t tbl [9];

   // Reference model state: winner of the next tie and the expected response
   int              m_tie_winner;
   logic            m_pv0, m_pv1;
   logic [XLEN-1:0] m_data;

   task automatic apply_reset();
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      m_tie_winner = 0; m_pv0 = 1'b0; m_pv1 = 1'b0; m_data = '0;
   endtask

   task automatic model_cycle(input int exp_grant);
      int g;
      if (req0_valid && req1_valid) g = m_tie_winner;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      else                          g = -1;
      @(negedge clk);
      if (exp_grant >= 0) check("contention_order", XLEN'(g), XLEN'(exp_grant));
      check("m_ready0", XLEN'(req0_ready), XLEN'(g == 0));
      check("m_ready1", XLEN'(req1_ready), XLEN'(g == 1));
      check_mux(g == 0, g == 1);
      check("m_rsp0", XLEN'(rsp0_valid), XLEN'(m_pv0));
      check("m_rsp1", XLEN'(rsp1_valid), XLEN'(m_pv1));
      check("m_data", rsp_data, m_data);
      m_pv0 = (g == 0);
      m_pv1 = (g == 1);
      if (g == 0) m_data = alu_f(req0_op, req0_a, req0_b);
      if (g == 1) m_data = alu_f(req1_op, req1_a, req1_b);
      if (g >= 0) m_tie_winner = 1 - g;
      @(posedge clk); #1;
   endtask

   initial begin
      tbl[0] = '{1, OP_ADD, 5, 7,          0, OP_ADD, 0, 0,              1, 0, 0, 0, 64'd0};
      tbl[1] = '{0, OP_ADD, 0, 0,          0, OP_ADD, 0, 0,              0, 0, 1, 0, 64'd12};
      tbl[2] = '{0, OP_ADD, 0, 0,          0, OP_ADD, 0, 0,              0, 0, 0, 0, 64'd12};
      tbl[3] = '{1, OP_SUB, 10, 3,         1, OP_XOR, 64'hF0, 64'h0F,    0, 1, 0, 0, 64'd12};
      tbl[4] = '{1, OP_SUB, 10, 3,         0, OP_XOR, 0, 0,              1, 0, 0, 1, 64'hFF};
      tbl[5] = '{0, OP_ADD, 0, 0,          0, OP_ADD, 0, 0,              0, 0, 1, 0, 64'd7};
      tbl[6] = '{0, OP_ADD, 0, 0,          1, OP_AND, 64'hFF00, 64'h0FF0, 0, 1, 0, 0, 64'd7};
      tbl[7] = '{0, OP_ADD, 0, 0,          1, OP_OR, 1, 2,               0, 1, 0, 1, 64'h0F00};
      tbl[8] = '{0, OP_ADD, 0, 0,          0, OP_ADD, 0, 0,              0, 0, 0, 1, 64'd3};

      rst_n = 1'b0;
      idle();
      #3;
      check("rst_rsp0", XLEN'(rsp0_valid), 0);
      check("rst_rsp1", XLEN'(rsp1_valid), 0);
      check("rst_data", rsp_data, 0);
      check("idle_ready0", XLEN'(req0_ready), 0);
      check("idle_ready1", XLEN'(req1_ready), 0);
      check_mux(1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].v0, tbl[i].op0, tbl[i].a0, tbl[i].b0,
               tbl[i].v1, tbl[i].op1, tbl[i].a1, tbl[i].b1);
         @(negedge clk);
         check($sformatf("vec%0d_ready0", i), XLEN'(req0_ready), XLEN'(tbl[i].g0));
         check($sformatf("vec%0d_ready1", i), XLEN'(req1_ready), XLEN'(tbl[i].g1));
         check($sformatf("vec%0d_rsp0", i), XLEN'(rsp0_valid), XLEN'(tbl[i].r0));
         check($sformatf("vec%0d_rsp1", i), XLEN'(rsp1_valid), XLEN'(tbl[i].r1));
         check($sformatf("vec%0d_data", i), rsp_data, tbl[i].d);
         check_mux(tbl[i].g0, tbl[i].g1);
         @(posedge clk); #1;
      end

      // Reset mid-operation drops the in-flight response and restores tie priority to 0
      drive(1, OP_ADD, 2, 2, 0, OP_ADD, 0, 0);
      @(negedge clk);
      check("rm_ready0", XLEN'(req0_ready), 1);
      @(posedge clk); #1;
      drive(1, OP_ADD, 5, 5, 0, OP_ADD, 0, 0);
      @(negedge clk);
      check("rm_rsp0_pre", XLEN'(rsp0_valid), 1);
      check("rm_data_pre", rsp_data, 4);
      rst_n = 1'b0;
      #1;
      check("rm_async_rsp0", XLEN'(rsp0_valid), 0);
      check("rm_async_data", rsp_data, 0);
      @(posedge clk); #1;
      check("rm_no_pulse", XLEN'(rsp0_valid), 0);
      check("rm_data_held0", rsp_data, 0);
      drive(1, OP_SUB, 10, 3, 1, OP_XOR, 64'hF0, 64'h0F);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("tie_first_ready0", XLEN'(req0_ready), 1);
      check("tie_first_ready1", XLEN'(req1_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("tie_second_ready1", XLEN'(req1_ready), 1);
      check("tie_rsp0", XLEN'(rsp0_valid), 1);
      check("tie_data0", rsp_data, 7);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      check("tie_rsp1", XLEN'(rsp1_valid), 1);
      check("tie_rsp0_low", XLEN'(rsp0_valid), 0);
      check("tie_data1", rsp_data, 64'hFF);
      @(posedge clk); #1;

      // Sustained contention, then randomized traffic against the model
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1, OP_ADD + 4'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
               1, OP_ADD + 4'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
         model_cycle(i % 2);
      end
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 2) != 0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 2) != 0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
         model_cycle(-1);
      end
      idle();
      model_cycle(-1);
      model_cycle(-1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
